// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// i2s_pkg : frame geometry and FSM state encoding shared by the I2S transmitter
// Rev 1.0
// ============================================================================
package i2s_pkg;

  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int SLOT_W     = $clog2(SLOT_BITS);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RUN  = 2'b11
  } i2s_state_t;

endpackage
`default_nettype wire

// File: rtl/i2s_ws_gen.sv
`default_nettype none
// ============================================================================
// i2s_ws_gen : 64-bit frame counter with slot index, word select and wrap flag
// Rev 1.0
// ============================================================================
module i2s_ws_gen
  import i2s_pkg::*;
(
  input  logic              clk_mic,
  input  logic              rst_mic_n,
  input  logic              advance,
  output logic [SLOT_W-1:0] slot,
  output logic              ws,
  output logic              wrap
);

  logic [CNT_W-1:0] r_bit_cnt;

  // Counter sits at 0 whenever it is not advancing, so every frame starts clean
  always_ff @(negedge clk_mic or negedge rst_mic_n) begin
    if (!rst_mic_n) begin
      r_bit_cnt <= '0;
    end else if (advance) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end else begin
      r_bit_cnt <= '0;
    end
  end

  assign slot = r_bit_cnt[SLOT_W-1:0];
  assign ws   = r_bit_cnt[CNT_W-1];
  assign wrap = (r_bit_cnt == CNT_W'(FRAME_BITS - 1));

endmodule
`default_nettype wire

// File: rtl/i2s_encoder.sv
`default_nettype none
// ============================================================================
// i2s_encoder : I2S bus-master transmitter, valid/ready sample input, MSB first
// Rev 1.0
// ============================================================================
module i2s_encoder
  import i2s_pkg::*;
#(
  parameter int DATAWIDTH       = 24,
  parameter bit UNDERRUN_REPEAT = 1'b1
) (
  input  logic                 clk_mic,
  input  logic                 rst_mic_n,
  input  logic                 en,
  input  logic                 s_valid,
  input  logic [DATAWIDTH-1:0] s_left,
  input  logic [DATAWIDTH-1:0] s_right,
  output logic                 s_ready,
  output logic                 WS,
  output logic                 DATA,
  output logic                 frame_start,
  output logic                 underrun
);

  localparam logic [SLOT_W-1:0] C_DW = SLOT_W'(DATAWIDTH);

  i2s_state_t           r_state;
  i2s_state_t           w_state_nxt;
  logic                 r_hold_full;
  logic [DATAWIDTH-1:0] r_hold_l, r_hold_r;
  logic [DATAWIDTH-1:0] r_last_l, r_last_r;
  logic [DATAWIDTH-1:0] r_sh_l, r_sh_r;
  logic [DATAWIDTH-1:0] w_refill_l, w_refill_r;
  logic                 r_frame_start, r_underrun;
  logic [SLOT_W-1:0]    w_slot;
  logic                 w_ws, w_wrap, w_advance;
  logic                 w_load_fresh, w_load_under, w_accept;
  logic                 w_in_word, w_shift;

  assign w_advance = (r_state == RUN);

  i2s_ws_gen u_ws_gen (
    .clk_mic   (clk_mic),
    .rst_mic_n (rst_mic_n),
    .advance   (w_advance),
    .slot      (w_slot),
    .ws        (w_ws),
    .wrap      (w_wrap)
  );

  always_ff @(negedge clk_mic or negedge rst_mic_n) begin
    if (!rst_mic_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_load_fresh = 1'b0;
    w_load_under = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (en) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (!en) begin
          w_state_nxt = IDLE;
        end else if (r_hold_full) begin
          w_state_nxt  = RUN;
          w_load_fresh = 1'b1;
        end
      end
      RUN: begin
        // Enable is only honoured at the frame boundary
        if (w_wrap) begin
          if (!en) begin
            w_state_nxt = IDLE;
          end else if (r_hold_full) begin
            w_load_fresh = 1'b1;
          end else begin
            w_load_under = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = s_valid && !r_hold_full;

  always_ff @(negedge clk_mic or negedge rst_mic_n) begin
    if (!rst_mic_n) begin
      r_hold_full <= 1'b0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
      r_hold_l    <= s_left;
      r_hold_r    <= s_right;
    end else if (w_load_fresh) begin
      r_hold_full <= 1'b0;
    end
  end

  generate
    if (UNDERRUN_REPEAT) begin : g_repeat
      assign w_refill_l = r_last_l;
      assign w_refill_r = r_last_r;
    end else begin : g_zero
      assign w_refill_l = '0;
      assign w_refill_r = '0;
    end
  endgenerate

  // Slots 1..DATAWIDTH carry the word; the shifter advances between those slots only
  assign w_in_word = (w_slot != '0) && (w_slot <= C_DW);
  assign w_shift   = w_advance && w_in_word && (w_slot != C_DW);

  always_ff @(negedge clk_mic or negedge rst_mic_n) begin
    if (!rst_mic_n) begin
      r_sh_l   <= '0;
      r_sh_r   <= '0;
      r_last_l <= '0;
      r_last_r <= '0;
    end else if (w_load_fresh) begin
      r_sh_l   <= r_hold_l;
      r_sh_r   <= r_hold_r;
      r_last_l <= r_hold_l;
      r_last_r <= r_hold_r;
    end else if (w_load_under) begin
      r_sh_l <= w_refill_l;
      r_sh_r <= w_refill_r;
    end else if (w_shift) begin
      if (w_ws) begin
        r_sh_r <= {r_sh_r[DATAWIDTH-2:0], 1'b0};
      end else begin
        r_sh_l <= {r_sh_l[DATAWIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(negedge clk_mic or negedge rst_mic_n) begin
    if (!rst_mic_n) begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_start <= w_load_fresh | w_load_under;
      r_underrun    <= w_load_under;
    end
  end

  assign s_ready     = !r_hold_full;
  assign WS          = w_ws;
  assign DATA        = w_in_word && (w_ws ? r_sh_r[DATAWIDTH-1] : r_sh_l[DATAWIDTH-1]);
  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_encoder.sv
`default_nettype none
// tb_i2s_encoder : randomized producer with a frame-level scoreboard; one instance
// repeats on underrun, the other zero-fills, both fed from the same producer.
module tb_i2s_encoder;

  localparam int DW = 24;
  localparam logic [63:0] WS_EXP = 64'hFFFF_FFFF_0000_0000;

  logic          clk_mic   = 1'b1;
  logic          rst_mic_n = 1'b0;
  logic          en        = 1'b0;
  logic          s_valid   = 1'b0;
  logic [DW-1:0] s_left    = '0;
  logic [DW-1:0] s_right   = '0;
  logic          s_ready0, ws0, data0, fs0, ur0;
  logic          s_ready1, ws1, data1, fs1, ur1;

  always #5 clk_mic = ~clk_mic;

  i2s_encoder #(.DATAWIDTH(DW), .UNDERRUN_REPEAT(1'b1)) dut0 (
    .clk_mic(clk_mic), .rst_mic_n(rst_mic_n), .en(en), .s_valid(s_valid),
    .s_left(s_left), .s_right(s_right), .s_ready(s_ready0), .WS(ws0),
    .DATA(data0), .frame_start(fs0), .underrun(ur0)
  );

  i2s_encoder #(.DATAWIDTH(DW), .UNDERRUN_REPEAT(1'b0)) dut1 (
    .clk_mic(clk_mic), .rst_mic_n(rst_mic_n), .en(en), .s_valid(s_valid),
    .s_left(s_left), .s_right(s_right), .s_ready(s_ready1), .WS(ws1),
    .DATA(data1), .frame_start(fs1), .underrun(ur1)
  );

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  always @(negedge clk_mic) edge_cnt <= edge_cnt + 1;

  task automatic chk_v(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    chk_v(name, 64'(act), 64'(exp));
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    chk_v(name, 64'(act), 64'(exp));
  endtask

  // Reference frame: slot 0 pad, slots 1..DW the word MSB first, rest zero
  function automatic logic [63:0] frame_vec(input logic [DW-1:0] l, input logic [DW-1:0] r);
    logic [63:0] v;
    logic [DW-1:0] w;
    int k;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      k = i % 32;
      w = (i < 32) ? l : r;
      if (k >= 1 && k <= DW) v[i] = w[DW - k];
    end
    return v;
  endfunction

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    int            e;
  } pair_t;

  pair_t         q[$];
  pair_t         p;
  logic [DW-1:0] last_l = '0, last_r = '0;
  logic [DW-1:0] e0l, e0r, e1l, e1r;
  logic [63:0]   ws0_v, d0_v, ws1_v, d1_v;
  bit            mon_en = 1'b0;
  bit            fresh;
  int            cap = -1;

  // Monitor: a pair is usable for a frame only if accepted on an earlier edge
  always @(posedge clk_mic) begin
    if (!mon_en) begin
      cap = -1;
    end else begin
      if (fs0) begin
        if (cap >= 0) chk_i("fs_period", cap, 64);
        fresh = (q.size() > 0) && (q[0].e < edge_cnt);
        if (fresh) begin
          p = q.pop_front();
          e0l = p.l; e0r = p.r; e1l = p.l; e1r = p.r;
          last_l = p.l; last_r = p.r;
        end else begin
          e0l = last_l; e0r = last_r; e1l = '0; e1r = '0;
        end
        chk_b("underrun0", ur0, !fresh);
        chk_b("frame_start1", fs1, 1'b1);
        chk_b("underrun1", ur1, !fresh);
        cap = 0;
      end else if (fs1 || ur0 || ur1) begin
        chk_v("stray_pulse", 64'({fs1, ur0, ur1}), 64'd0);
      end
      if (cap >= 0 && cap < 64) begin
        ws0_v[cap] = ws0; d0_v[cap] = data0;
        ws1_v[cap] = ws1; d1_v[cap] = data1;
        cap++;
        if (cap == 64) begin
          chk_v("ws_frame0", ws0_v, WS_EXP);
          chk_v("data_frame0", d0_v, frame_vec(e0l, e0r));
          chk_v("ws_frame1", ws1_v, WS_EXP);
          chk_v("data_frame1", d1_v, frame_vec(e1l, e1r));
        end
      end else if (!fs0) begin
        chk_v("idle_outputs", 64'({ws0, data0, ws1, data1}), 64'd0);
      end
    end
  end

  // Offer one pair from a posedge; returns at the posedge after the accept edge
  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int t;
    t = 0;
    s_left = l; s_right = r; s_valid = 1'b1;
    while (!s_ready0 && t < 300) begin
      @(posedge clk_mic);
      t++;
    end
    if (t >= 300) begin
      chk_i("accept_timeout", t, 0);
    end else begin
      q.push_back('{l, r, edge_cnt + 1});
    end
    @(posedge clk_mic);
    s_valid = 1'b0;
  endtask

  task automatic wait_fs();
    int t;
    t = 0;
    while (!fs0 && t < 200) begin
      @(posedge clk_mic);
      t++;
    end
    chk_b("fs_seen", fs0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    int acc, nfs, nur;
    bit pend;

    #23;
    chk_v("reset_dut0", 64'({ws0, data0, fs0, ur0, s_ready0}), 64'b00001);
    chk_v("reset_dut1", 64'({ws1, data1, fs1, ur1, s_ready1}), 64'b00001);
    @(posedge clk_mic);
    rst_mic_n = 1'b1; en = 1'b1; mon_en = 1'b1;
    repeat (3) @(posedge clk_mic);

    // First pair from WAIT: pulse on the next edge, MSB one edge later
    send(24'h800001, 24'h7FFFFF);
    chk_b("lat_edge_n", fs0, 1'b0);
    @(posedge clk_mic);
    chk_b("lat_edge_n1_fs", fs0, 1'b1);
    @(posedge clk_mic);
    chk_b("lat_edge_n2_msb", data0, 1'b1);
    repeat (150) @(posedge clk_mic);

    send(24'h123456, 24'hABCDEF);
    repeat (200) @(posedge clk_mic);

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 90)) @(posedge clk_mic);
      send(DW'($urandom), DW'($urandom));
    end
    repeat (150) @(posedge clk_mic);

    // Continuous producer: one transfer per frame, no underrun
    v = 24'h000100; acc = 0; nfs = 0; nur = 0; pend = 1'b0;
    s_left = v; s_right = ~v; s_valid = 1'b1;
    for (int c = 0; c < 640; c++) begin
      if (s_ready0) begin
        q.push_back('{s_left, s_right, edge_cnt + 1});
        pend = 1'b1;
        if (c >= 128) acc++;
      end
      if (c >= 128) begin
        if (fs0) nfs++;
        if (ur0) nur++;
      end
      @(posedge clk_mic);
      if (pend) begin
        v = v + 1'b1; s_left = v; s_right = ~v; pend = 1'b0;
      end
    end
    s_valid = 1'b0;
    chk_i("cont_frames", nfs, 8);
    chk_i("cont_underruns", nur, 0);
    chk_i("cont_accepts", acc, 8);
    repeat (200) @(posedge clk_mic);

    // Enable dropped at bit_cnt 10: the frame completes, then idle
    send(DW'($urandom), DW'($urandom));
    wait_fs();
    repeat (10) @(posedge clk_mic);
    en = 1'b0;
    repeat (54) @(posedge clk_mic);
    nfs = 0;
    repeat (60) begin
      if (fs0) nfs++;
      @(posedge clk_mic);
    end
    chk_i("no_frame_after_disable", nfs, 0);
    chk_b("ready_idle_empty", s_ready0, 1'b1);
    send(24'h0F0F0F, 24'hF0F0F0);
    repeat (5) @(posedge clk_mic);
    chk_b("ready_idle_held", s_ready0, 1'b0);
    en = 1'b1;
    repeat (200) @(posedge clk_mic);

    // Asynchronous reset at bit_cnt 40 with the holding register full
    wait_fs();
    repeat (5) @(posedge clk_mic);
    send(DW'($urandom), DW'($urandom));
    repeat (34) @(posedge clk_mic);
    mon_en = 1'b0;
    chk_b("ws_before_reset", ws0, 1'b1);
    #2;
    rst_mic_n = 1'b0;
    #1;
    chk_v("async_reset_dut0", 64'({ws0, data0, fs0, ur0, s_ready0}), 64'b00001);
    chk_v("async_reset_dut1", 64'({ws1, data1, fs1, ur1, s_ready1}), 64'b00001);
    q.delete();
    last_l = '0; last_r = '0;
    repeat (3) @(posedge clk_mic);
    rst_mic_n = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(posedge clk_mic);
    send(24'h5A5A5A, 24'h3C3C3C);
    repeat (220) @(posedge clk_mic);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
